// File: rtl/drop_arbiter.sv
// rtl/drop_arbiter.sv - Connect Four turn scheduler owning the column-drop write port (optional UNDO_EN undo stack)
module drop_arbiter #(
  parameter int AI_TIMEOUT = 1000000,
  parameter int ROWS       = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mode_i,
  input  logic        term_i,
  input  logic [20:0] column_counts_i,
  input  logic        human_req_i,
  input  logic [2:0]  human_col_i,
  input  logic        ai_req_i,
  input  logic [2:0]  ai_col_i,
`ifdef UNDO_EN
  input  logic        undo_i,
  output logic        clr_en_o,
  output logic [2:0]  clr_col_o,
`endif
  output logic        ai_start_o,
  output logic        wr_en_o,
  output logic [2:0]  wr_col_o,
  output logic        wr_player_o,
  output logic        player_o,
  output logic        illegal_o,
  output logic        ai_fault_o,
  output logic        draw_o,
  output logic        busy_o
);

  localparam int         TW       = (AI_TIMEOUT > 2) ? $clog2(AI_TIMEOUT) : 1;
  localparam logic [5:0] MAX_MOVE = 6'd42;

  typedef enum logic [2:0] {
    IDLE, WAIT_H, COMMIT, SETTLE, AI_START, AI_WAIT, DONE
`ifdef UNDO_EN
    , UNDO
`endif
  } state_t;

  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic          player_q, player_d;
  logic [5:0]    moves_q, moves_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          wr_en_q, wr_en_d;
  logic [2:0]    wr_col_q, wr_col_d;
  logic          wr_player_q, wr_player_d;
  logic          illegal_q, illegal_d;
  logic          ai_fault_q, ai_fault_d;
  logic          ai_start_q, ai_start_d;
  logic          draw_q, draw_d;
  logic          busy_q, busy_d;
  logic [2:0]    fb_col;
`ifdef UNDO_EN
  logic          clr_en_q, clr_en_d;
  logic [2:0]    clr_col_q, clr_col_d;
  logic [1:0]    pops_q, pops_d;
  logic [2:0]    hist_q [42];
`endif

  // A column accepts a piece only if it exists and is not yet full.
  function automatic logic col_legal(input logic [2:0] c, input logic [20:0] counts);
    logic [23:0] ext;
    logic [2:0]  cnt;
    ext = {3'd0, counts};
    cnt = ext[5'(c) * 5'd3 +: 3];
    return (c != 3'd7) && ({29'd0, cnt} < 32'(ROWS));
  endfunction

  // Lowest-index legal column; scanning downward lets the lowest hit win.
  function automatic logic [2:0] fallback_of(input logic [20:0] counts);
    logic [2:0] f;
    f = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (col_legal(3'(i), counts)) f = 3'(i);
    end
    return f;
  endfunction

  assign fb_col = fallback_of(column_counts_i);

  // Next-state and registered-output decisions for the turn FSM.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    player_d    = player_q;
    moves_d     = moves_q;
    tmo_d       = tmo_q;
    wr_en_d     = 1'b0;
    wr_col_d    = wr_col_q;
    wr_player_d = wr_player_q;
    illegal_d   = 1'b0;
    ai_fault_d  = 1'b0;
    ai_start_d  = 1'b0;
    draw_d      = draw_q;
`ifdef UNDO_EN
    clr_en_d    = 1'b0;
    clr_col_d   = clr_col_q;
    pops_d      = pops_q;
`endif
    case (state_q)
      IDLE: begin
        mode_d  = mode_i;
        state_d = WAIT_H;
      end
      WAIT_H: begin
        if (human_req_i) begin
          if (col_legal(human_col_i, column_counts_i)) begin
            state_d     = COMMIT;
            wr_en_d     = 1'b1;
            wr_col_d    = human_col_i;
            wr_player_d = player_q;
          end else begin
            illegal_d = 1'b1;
          end
        end
`ifdef UNDO_EN
        else if (undo_i && (moves_q != 6'd0)) begin
          state_d = UNDO;
          pops_d  = (mode_q && (moves_q >= 6'd2)) ? 2'd2 : 2'd1;
        end
`endif
      end
      COMMIT: begin
        if (moves_q < MAX_MOVE) moves_d = moves_q + 6'd1;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (term_i) begin
          state_d = DONE;
        end else if (moves_q == MAX_MOVE) begin
          state_d = DONE;
          draw_d  = 1'b1;
        end else begin
          player_d = ~player_q;
          if (mode_q && !player_q) begin
            state_d    = AI_START;
            ai_start_d = 1'b1;
          end else begin
            state_d = WAIT_H;
          end
        end
      end
      AI_START: begin
        tmo_d   = '0;
        state_d = AI_WAIT;
      end
      AI_WAIT: begin
        if (ai_req_i || (tmo_q == TW'(AI_TIMEOUT - 1))) begin
          state_d     = COMMIT;
          wr_en_d     = 1'b1;
          wr_player_d = player_q;
          if (ai_req_i && col_legal(ai_col_i, column_counts_i)) begin
            wr_col_d = ai_col_i;
          end else begin
            wr_col_d   = fb_col;
            ai_fault_d = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
`ifdef UNDO_EN
      UNDO: begin
        clr_en_d  = 1'b1;
        clr_col_d = hist_q[moves_q - 6'd1];
        moves_d   = moves_q - 6'd1;
        pops_d    = pops_q - 2'd1;
        if (pops_q == 2'd1) begin
          state_d = WAIT_H;
          if (!mode_q) player_d = ~player_q;
        end
      end
`endif
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A win seen outside COMMIT/SETTLE freezes everything; COMMIT finishes and SETTLE handles term itself.
    if (term_i && (state_q != COMMIT) && (state_q != SETTLE) && (state_q != DONE)) begin
      state_d     = DONE;
      player_d    = player_q;
      moves_d     = moves_q;
      tmo_d       = tmo_q;
      wr_en_d     = 1'b0;
      wr_col_d    = wr_col_q;
      wr_player_d = wr_player_q;
      illegal_d   = 1'b0;
      ai_fault_d  = 1'b0;
      ai_start_d  = 1'b0;
`ifdef UNDO_EN
      clr_en_d    = 1'b0;
      clr_col_d   = clr_col_q;
`endif
    end
    busy_d = (state_d != IDLE) && (state_d != DONE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      player_q    <= 1'b0;
      moves_q     <= 6'd0;
      tmo_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_col_q    <= 3'd0;
      wr_player_q <= 1'b0;
      illegal_q   <= 1'b0;
      ai_fault_q  <= 1'b0;
      ai_start_q  <= 1'b0;
      draw_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UNDO_EN
      clr_en_q    <= 1'b0;
      clr_col_q   <= 3'd0;
      pops_q      <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      player_q    <= player_d;
      moves_q     <= moves_d;
      tmo_q       <= tmo_d;
      wr_en_q     <= wr_en_d;
      wr_col_q    <= wr_col_d;
      wr_player_q <= wr_player_d;
      illegal_q   <= illegal_d;
      ai_fault_q  <= ai_fault_d;
      ai_start_q  <= ai_start_d;
      draw_q      <= draw_d;
      busy_q      <= busy_d;
`ifdef UNDO_EN
      clr_en_q    <= clr_en_d;
      clr_col_q   <= clr_col_d;
      pops_q      <= pops_d;
`endif
    end
  end

`ifdef UNDO_EN
  // History stack is indexed by the move counter, so push lands at the current depth.
  always_ff @(posedge clk_i) begin
    if ((state_q == COMMIT) && (moves_q < MAX_MOVE)) hist_q[moves_q] <= wr_col_q;
  end

  assign clr_en_o  = clr_en_q;
  assign clr_col_o = clr_col_q;
`endif

  assign ai_start_o  = ai_start_q;
  assign wr_en_o     = wr_en_q;
  assign wr_col_o    = wr_col_q;
  assign wr_player_o = wr_player_q;
  assign player_o    = player_q;
  assign illegal_o   = illegal_q;
  assign ai_fault_o  = ai_fault_q;
  assign draw_o      = draw_q;
  assign busy_o      = busy_q;

endmodule

// File: doc/drop_arbiter.md
Name: drop_arbiter

Overview:
- Turn scheduler that owns the single board write port (column drop) of the Connect Four datapath.
- Two requesters share that port: the human input handler (debounced middle-button drop plus selected column) and the minimax move engine.
- It enforces turn order, rejects illegal drops, starts the AI and bounds its latency with a timeout fallback, and counts moves to detect a full-board draw.

Parameters:
- AI_TIMEOUT, 1000000, cycles allowed in AI_WAIT before the fallback column is used (minimum 2).
- ROWS, 6, column height; a column is full when its count is ≥ ROWS.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- mode  in  1  0 = player vs player, 1 = player 0 (human) vs AI (player 1); sampled only in IDLE.
- term  in  1  win detected by the board checker; level.
- column_counts  in  21  per-column fill count; column c occupies bits [3c+2:3c].
- human_req  in  1  single-cycle drop request.
- human_col  in  3  column for human_req.
- ai_req  in  1  single-cycle move-ready from the engine.
- ai_col  in  3  column for ai_req.
- ai_start  out  1  one-cycle pulse that launches the engine.
- wr_en  out  1  one-cycle board write strobe.
- wr_col  out  3  column being written.
- wr_player  out  1  owner of the written piece.
- player  out  1  side to move.
- illegal  out  1  one-cycle pulse when a request is rejected.
- ai_fault  out  1  one-cycle pulse when the fallback column replaced the AI move.
- draw  out  1  level; the board filled with no win.
- busy  out  1  high in every state except IDLE and DONE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; player=0; all pulses 0; wr_col=0; wr_player=0; draw=0; move counter=0; timeout counter=0.
- All outputs are registered.
- Column c is legal iff c≤6 and column_counts[3c+2:3c] < ROWS.
- IDLE: one cycle after reset release, latch mode → WAIT_H.
- WAIT_H (human to move):
  - human_req with a legal column → COMMIT; wr_en=1 on the next cycle.
  - human_req with an illegal column → illegal=1 next cycle; stay in WAIT_H.
  - ai_req is ignored.
- COMMIT (1 cycle):
  - wr_en=1, wr_col=latched column, wr_player=player.
  - Move counter increments, saturating at 42.
  - Next state is SETTLE.
- SETTLE (1 cycle): allows column_counts and term to update. Then, in priority order:
  - term=1 → DONE.
  - Move counter=42 → DONE with draw=1.
  - Otherwise player toggles. If mode=1 and the new player=1 → AI_START; else → WAIT_H.
- AI_START (1 cycle): ai_start=1; clear the timeout counter; → AI_WAIT.
- AI_WAIT:
  - human_req is ignored and does not pulse illegal.
  - ai_req with a legal column → COMMIT with that column.
  - ai_req with an illegal column → ai_fault=1; COMMIT with the fallback column.
  - Timeout counter reaching AI_TIMEOUT-1 → ai_fault=1; COMMIT with the fallback column.
  - If ai_req and the timeout coincide, ai_req wins.
  - Fallback column = lowest-index legal column. One always exists here, because the move counter is below 42.
- DONE: outputs hold; all requests are ignored; leave only by reset.
- term rising in any state other than SETTLE → DONE on the next cycle. An in-flight COMMIT still completes first.
- Latency:
  - Human: request at cycle N → wr_en at N+1.
  - AI: ai_start at cycle N → earliest wr_en at N+2.

Optional Feature:
- Macro: UNDO_EN.
- When defined:
  - Adds input undo (single-cycle), outputs clr_en (1) and clr_col (3), and a 42x3 history stack of committed columns.
  - In WAIT_H, undo with move counter≥1 → UNDO state. UNDO issues one clr_en pulse per popped entry, one per cycle, with clr_col = popped column.
  - mode=0: pop 1 entry; player toggles.
  - mode=1: pop 2 entries (AI reply plus the human move); player stays 0. If only 1 entry is present, pop 1.
  - Move counter decrements per pop. Undo is ignored with an empty stack, in AI_WAIT, and in DONE.
- When undefined: none of these ports or logic exist, and the stack is not built.

Test Plan:
- PvP drop: mode=0, human_req col 3 → wr_en at the next cycle with wr_col=3, wr_player=0; after SETTLE, player=1.
- Full column: column_counts col 2=6, human_req col 2 → illegal=1 for 1 cycle; no wr_en; state stays WAIT_H. col=7 → same response.
- AI handshake: mode=1, human col 0 commits → ai_start pulses once; ai_req col 5 → wr_en with wr_col=5, wr_player=1; player returns to 0.
- AI timeout: AI_TIMEOUT=16, counts col0=6 and col1=3, no ai_req → ai_fault and wr_col=1 after 16 cycles in AI_WAIT.
- Draw/term:
  - 42 legal commits with term=0 → draw=1, state DONE; further requests produce no wr_en.
  - term=1 during SETTLE → DONE with draw=0.
- Reset mid-AI_WAIT: rst low asynchronously → ai_start, wr_en and player are 0 immediately. After release, IDLE then WAIT_H. With UNDO_EN: in mode=1 after 4 moves, undo → two clr_en pulses, popping the AI column first, then the human column.
